// File: rtl/mips32_reg_dump_if.sv
// Register-file read port plus the {index, value} dump stream of mips32_reg_dump.
// master = the dump engine, slave = register file / stream consumer.
interface mips32_reg_dump_if;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        dump_valid;
    logic        dump_ready;
    logic [4:0]  dump_idx;
    logic [31:0] dump_data;
    logic        dump_last;

    modport master (
        output rd_addr,
        input  rd_data,
        output dump_valid,
        input  dump_ready,
        output dump_idx,
        output dump_data,
        output dump_last
    );

    modport slave (
        input  rd_addr,
        output rd_data,
        input  dump_valid,
        output dump_ready,
        input  dump_idx,
        input  dump_data,
        input  dump_last
    );
endinterface

// File: rtl/mips32_reg_dump.sv
// Scans a register-file window after a halt edge or start pulse and streams {index, value} beats.
// Optional DUMP_CHECKSUM_EN appends a beat (index 31) carrying the XOR of all dumped values.
//
// state | meaning
// IDLE  | waiting for trigger
// REQ   | rd_addr holds idx, register file is reading
// WAIT  | rd_data valid, captured into the beat registers
// SEND  | register beat offered, waiting for acceptance
// CSUM  | checksum beat offered (DUMP_CHECKSUM_EN only)
// DONE  | done pulse, back to IDLE
module mips32_reg_dump #(
    parameter int FIRST_REG = 0,
    parameter int NUM_REGS  = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic halted,
    input  logic start,
    output logic busy,
    output logic done,
    mips32_reg_dump_if.master bus
);

    if (FIRST_REG + NUM_REGS > 32 || NUM_REGS < 1 || FIRST_REG < 0) begin : g_param_check
        $error("mips32_reg_dump: register window exceeds the 32-entry register file");
    end

    localparam logic [5:0] FIRST_IDX = 6'(FIRST_REG);
    localparam logic [5:0] LAST_IDX  = 6'(FIRST_REG + NUM_REGS - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        SEND,
`ifdef DUMP_CHECKSUM_EN
        CSUM,
`endif
        DONE
    } state_t;

    state_t     state;
    logic       halted_q;
    logic [5:0] idx;
    logic       trigger;
`ifdef DUMP_CHECKSUM_EN
    logic [31:0] csum;
`endif

    assign trigger = start | (halted & ~halted_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            halted_q       <= 1'b0;
            idx            <= FIRST_IDX;
            bus.rd_addr    <= 5'(FIRST_REG);
            bus.dump_valid <= 1'b0;
            bus.dump_idx   <= 5'd0;
            bus.dump_data  <= 32'd0;
            bus.dump_last  <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            csum           <= 32'd0;
`endif
        end else begin
            halted_q <= halted;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        idx         <= FIRST_IDX;
                        bus.rd_addr <= 5'(FIRST_REG);
                        busy        <= 1'b1;
                        state       <= REQ;
`ifdef DUMP_CHECKSUM_EN
                        csum        <= 32'd0;
`endif
                    end
                end
                REQ: state <= WAIT;
                WAIT: begin
                    bus.dump_data  <= bus.rd_data;
                    bus.dump_idx   <= idx[4:0];
                    bus.dump_valid <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
                    bus.dump_last  <= 1'b0;
                    csum           <= csum ^ bus.rd_data;
`else
                    bus.dump_last  <= (idx == LAST_IDX);
`endif
                    state          <= SEND;
                end
                SEND: begin
                    if (bus.dump_ready) begin
                        if (idx == LAST_IDX) begin
`ifdef DUMP_CHECKSUM_EN
                            // checksum beat follows immediately, valid stays high
                            bus.dump_idx  <= 5'h1f;
                            bus.dump_data <= csum;
                            bus.dump_last <= 1'b1;
                            state         <= CSUM;
`else
                            bus.dump_valid <= 1'b0;
                            bus.dump_last  <= 1'b0;
                            done           <= 1'b1;
                            state          <= DONE;
`endif
                        end else begin
                            bus.dump_valid <= 1'b0;
                            idx            <= idx + 6'd1;
                            bus.rd_addr    <= 5'(idx + 6'd1);
                            state          <= REQ;
                        end
                    end
                end
`ifdef DUMP_CHECKSUM_EN
                CSUM: begin
                    if (bus.dump_ready) begin
                        bus.dump_valid <= 1'b0;
                        bus.dump_last  <= 1'b0;
                        done           <= 1'b1;
                        state          <= DONE;
                    end
                end
`endif
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
